gcd_operand_sequencer: RTL and testbench

- Upstream/downstream wrapper for the iterative subtractive GCD core.
- Accepts operand pairs (A, B) on a valid/ready port and buffers them in a small FIFO.
- Serialises each pair onto the core's single data bus: A in the first load cycle, B in the second.
- Waits for the core's done, then returns the result on a valid/ready output port. Zero operands bypass the core, and a watchdog bounds every run.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_operand_sequencer_if.sv | 26 ++
 rtl/gcd_pair_fifo.sv | 57 +++++
 rtl/gcd_operand_sequencer.sv | 121 ++++++++++++
 tb/tb_gcd_operand_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD operand sequencer and its pair FIFO.
package gcd_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] a;
    logic [GCD_WIDTH-1:0] b;
  } pair_t;

endpackage

// File: rtl/gcd_operand_sequencer_if.sv
// Upstream pair port, core bus and result port of the GCD operand sequencer.
interface gcd_operand_sequencer_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    output in_ready, gcd_start, gcd_data, out_valid, out_gcd, out_err, busy
  );

  modport master (
    output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    input  in_ready, gcd_start, gcd_data, out_valid, out_gcd, out_err, busy
  );
endinterface

// File: rtl/gcd_pair_fifo.sv
// Count-based FIFO of {a,b} operand pairs with a registered ready flag.
module gcd_pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic               pop,
  output logic [2*WIDTH-1:0] rdata,
  output logic               empty,
  output logic               ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0][2*WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // ready looks one push ahead so a full FIFO never offers a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      ready <= (count_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds queued operand pairs to the subtractive GCD core one at a time and
// returns each result; zero operands skip the core, a watchdog bounds each run.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst,
  gcd_operand_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a, head_b;
  logic [WIDTH-1:0]   op_a, op_b, res_q;
  logic               err_q;
  logic [TW-1:0]      timer;
  logic               empty, fifo_ready, pop;
  logic               head_zero, done_ok, timeout;

  logic               start_c, valid_c, busy_c;
  logic [WIDTH-1:0]   data_c;

  gcd_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .ready (fifo_ready)
  );

  assign {head_a, head_b} = head;
  assign head_zero = (head_a == '0) || (head_b == '0);
  // timer==0 marks the first WAIT cycle, where done is still the previous run's
  assign done_ok = bus.gcd_done && (timer != '0);
  assign timeout = (timer == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (!empty) state_nxt = head_zero ? S_OUT : S_LOAD_A;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_WAIT;
      S_WAIT:   if (done_ok || timeout) state_nxt = S_OUT;
      S_OUT:    if (bus.out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_c = 1'b0;
    data_c  = '0;
    valid_c = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE:   pop = !empty;
      S_LOAD_A: begin start_c = 1'b1; data_c = op_a; end
      S_LOAD_B: data_c = op_b;
      S_WAIT:   data_c = op_b;
      S_OUT:    valid_c = 1'b1;
      default:  ;
    endcase
    busy_c = (state != S_IDLE) || !empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      timer <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          op_a <= head_a;
          op_b <= head_b;
          if (head_zero) begin
            res_q <= head_a | head_b;
            err_q <= 1'b0;
          end
        end
        S_LOAD_B: timer <= '0;
        S_WAIT: begin
          timer <= timer + T_ONE;
          if (done_ok) begin
            res_q <= bus.gcd_result;
            err_q <= 1'b0;
          end else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = fifo_ready;
  assign bus.gcd_start = start_c;
  assign bus.gcd_data  = data_c;
  assign bus.out_valid = valid_c;
  assign bus.out_gcd   = res_q;
  assign bus.out_err   = err_q;
  assign bus.busy      = busy_c;
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Randomised bench for gcd_operand_sequencer with a behavioural GCD core model.
module tb_gcd_operand_sequencer;
  import gcd_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gcd_operand_sequencer_if #(.WIDTH(W)) bus ();

  gcd_operand_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // core model: mode 0 normal, 1 never done, 2 stale done held into first WAIT
  int core_mode = 0, core_lat = 0, core_ph = 0, core_cnt = 0, starts = 0;
  logic [W-1:0] ca = '0, cb = '0, core_res = '0;
  logic core_done = 1'b0;
  assign bus.gcd_done   = core_done;
  assign bus.gcd_result = core_res;

  function automatic logic [W-1:0] core_sub(logic [W-1:0] a, logic [W-1:0] b);
    while (a != b) if (a > b) a = a - b; else b = b - a;
    return a;
  endfunction

  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  always @(posedge clk) begin
    if (bus.gcd_start) begin
      starts++;
      ca = bus.gcd_data;
      core_ph = 1;
      if (core_mode == 2) begin core_done <= 1'b1; core_res <= 16'hBEEF; end
      else core_done <= 1'b0;
    end else if (core_ph == 1) begin
      cb = bus.gcd_data; core_ph = 2; core_cnt = core_lat;
    end else if (core_ph == 2) begin
      core_done <= 1'b0; core_ph = 3;
    end else if (core_ph == 3 && core_mode != 1) begin
      if (core_cnt == 0) begin
        core_done <= 1'b1; core_res <= core_sub(ca, cb); core_ph = 0;
      end else core_cnt--;
    end
  end

  task automatic push(input int a, input int b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = W'(a); bus.in_b = W'(b);
    while (!bus.in_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: in_ready=%0b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(output logic [W-1:0] g, output logic e, output bit ok);
    int n = 0;
    ok = 0; g = '0; e = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && n < 300) begin @(negedge clk); n++; end
    if (bus.out_valid) begin
      ok = 1; g = bus.out_gcd; e = bus.out_err;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic wait_start(output bit seen);
    int n = 0;
    while (!bus.gcd_start && n < 100) begin @(negedge clk); n++; end
    seen = bus.gcd_start;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.gcd_start, bus.out_err, bus.busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.in_ready, bus.out_valid, bus.gcd_start, bus.out_err, bus.busy});
    end
    n_cmp++;
    if (bus.gcd_data !== '0 || bus.out_gcd !== '0) begin
      n_err++;
      $display("FAIL reset_data: gcd_data=%0d out_gcd=%0d want 0", bus.gcd_data, bus.out_gcd);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_core_basic();
    bit seen, ok; logic [W-1:0] g; logic e; int s0, n;
    core_mode = 0; core_lat = 3; s0 = starts;
    push(143, 78);
    wait_start(seen);
    n_cmp++;
    if (!seen || bus.gcd_data !== W'(143)) begin
      n_err++;
      $display("FAIL load_a: start=%b data=%0d want 1/143", seen, bus.gcd_data);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.gcd_start !== 1'b0 || bus.gcd_data !== W'(78)) begin
      n_err++;
      $display("FAIL load_b: start=%b data=%0d want 0/78", bus.gcd_start, bus.gcd_data);
    end
    n = 0;
    while (!bus.gcd_done && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL early_valid: out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL done_latency: out_valid=%b want 1", bus.out_valid);
    end
    recv(g, e, ok);
    n_cmp++;
    if (!ok || g !== W'(13) || e !== 1'b0) begin
      n_err++; $display("FAIL gcd_143_78: got %0d err=%b want 13 err=0", g, e);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || starts - s0 != 1) begin
      n_err++;
      $display("FAIL single_handshake: out_valid=%b starts=%0d want 0/1", bus.out_valid, starts - s0);
    end
  endtask

  task automatic test_bypass();
    bit ok; logic [W-1:0] g; logic e; int s0;
    int ea[3] = '{0, 0, 36};
    int eb[3] = '{25, 0, 0};
    int ex[3] = '{25, 0, 36};
    s0 = starts;
    push(ea[0], eb[0]);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bypass_pop_cycle: out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL bypass_latency: out_valid=%b want 1", bus.out_valid);
    end
    recv(g, e, ok);
    n_cmp++;
    if (!ok || g !== W'(ex[0]) || e !== 1'b0) begin
      n_err++; $display("FAIL bypass_0: got %0d err=%b want %0d", g, e, ex[0]);
    end
    push(ea[1], eb[1]);
    push(ea[2], eb[2]);
    for (int i = 1; i < 3; i++) begin
      recv(g, e, ok);
      n_cmp++;
      if (!ok || g !== W'(ex[i]) || e !== 1'b0) begin
        n_err++; $display("FAIL bypass_%0d: got %0d err=%b want %0d", i, g, e, ex[i]);
      end
    end
    n_cmp++;
    if (starts != s0) begin
      n_err++; $display("FAIL bypass_no_start: starts=%0d want %0d", starts, s0);
    end
  endtask

  task automatic test_fill();
    bit ok; logic [W-1:0] g; logic e;
    pair_t q[$];
    int pa[5] = '{48, 17, 100, 81, 1000};
    int pb[5] = '{18, 5, 40, 27, 999};
    core_mode = 0; core_lat = 1;
    for (int i = 0; i < D + 1; i++) begin
      push(pa[i], pb[i]);
      q.push_back('{a: W'(pa[i]), b: W'(pb[i])});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL fill_full: in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy);
    end
    while (q.size() > 0) begin
      pair_t p = q.pop_front();
      recv(g, e, ok);
      n_cmp++;
      if (!ok || g !== W'(ref_gcd(int'(p.a), int'(p.b))) || e !== 1'b0) begin
        n_err++;
        $display("FAIL fill_order: gcd(%0d,%0d) got %0d err=%b want %0d",
                 p.a, p.b, g, e, ref_gcd(int'(p.a), int'(p.b)));
      end
    end
  endtask

  task automatic test_timeout();
    bit seen, ok; logic [W-1:0] g; logic e; int n;
    core_mode = 1;
    push(9, 6);
    wait_start(seen);
    n = 0;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (!seen || n != TO + 2) begin
      n_err++; $display("FAIL timeout_latency: cycles=%0d want %0d", n, TO + 2);
    end
    recv(g, e, ok);
    n_cmp++;
    if (!ok || g !== '0 || e !== 1'b1) begin
      n_err++; $display("FAIL timeout_result: got %0d err=%b want 0 err=1", g, e);
    end
    core_mode = 0; core_lat = 2;
    push(9, 6);
    recv(g, e, ok);
    n_cmp++;
    if (!ok || g !== W'(3) || e !== 1'b0) begin
      n_err++; $display("FAIL after_timeout: got %0d err=%b want 3 err=0", g, e);
    end
  endtask

  task automatic test_stale();
    bit seen, ok; logic [W-1:0] g; logic e;
    core_mode = 2; core_lat = 2;
    push(21, 14);
    wait_start(seen);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (!seen || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL stale_captured: out_valid=%b want 0", bus.out_valid);
    end
    recv(g, e, ok);
    n_cmp++;
    if (!ok || g !== W'(7) || e !== 1'b0) begin
      n_err++; $display("FAIL stale_result: got %0d err=%b want 7 err=0", g, e);
    end
    core_mode = 0;
  endtask

  task automatic test_random();
    bit ok; logic [W-1:0] g; logic e; int a, b;
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4095));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4095));
      core_lat = int'($urandom_range(0, 4));
      push(a, b);
      recv(g, e, ok);
      n_cmp++;
      if (!ok || g !== W'(ref_gcd(a, b)) || e !== 1'b0) begin
        n_err++; $display("FAIL random: gcd(%0d,%0d) got %0d err=%b want %0d", a, b, g, e, ref_gcd(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [W-1:0] g; logic e;
    pair_t q[$];
    for (int i = 0; i < 3; i++) begin
      pair_t p;
      p.a = W'($urandom_range(1, 999));
      p.b = W'($urandom_range(1, 999));
      push(int'(p.a), int'(p.b));
      q.push_back(p);
    end
    while (q.size() > 0) begin
      pair_t p = q.pop_front();
      recv(g, e, ok);
      n_cmp++;
      if (!ok || g !== W'(ref_gcd(int'(p.a), int'(p.b)))) begin
        n_err++; $display("FAIL back_to_back: gcd(%0d,%0d) got %0d want %0d",
                          p.a, p.b, g, ref_gcd(int'(p.a), int'(p.b)));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [W-1:0] g; logic e; int bad = 0;
    core_mode = 1;
    push(50, 20);
    push(7, 3);
    push(8, 4);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.gcd_data !== W'(20)) begin
      n_err++; $display("FAIL mid_wait: busy=%b gcd_data=%0d want 1/20", bus.busy, bus.gcd_data);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.gcd_start, bus.out_err, bus.busy} !== 5'b0 ||
        bus.gcd_data !== '0 || bus.out_gcd !== '0) begin
      n_err++;
      $display("FAIL mid_reset: flags=%b gcd_data=%0d out_gcd=%0d want 0",
               {bus.in_ready, bus.out_valid, bus.gcd_start, bus.out_err, bus.busy},
               bus.gcd_data, bus.out_gcd);
    end
    @(negedge clk);
    rst = 1'b0;
    core_mode = 0; core_lat = 1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL discarded: bad_cycles=%0d in_ready=%b want 0/1", bad, bus.in_ready);
    end
    push(100, 75);
    recv(g, e, ok);
    n_cmp++;
    if (!ok || g !== W'(25) || e !== 1'b0) begin
      n_err++; $display("FAIL post_reset: got %0d err=%b want 25 err=0", g, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_core_basic();
    test_bypass();
    test_fill();
    test_timeout();
    test_stale();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
